// File: rtl/prpg_checker.sv
// PRPG stream checker: seeds a local LFSR from the received stream, then predicts each following bit.
// It reports lock status, a per-bit error strobe, and saturating error and bit counters.
module prpg_checker #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
    parameter int unsigned      LOCK_CNT    = 4,
    parameter int unsigned      LOSS_THRESH = 3,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Load,
    input  logic             Din_valid,
    input  logic             Din,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int unsigned SW = $clog2(WIDTH + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(LOSS_THRESH + 1);

    localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] r, r_nxt, r_din, r_pred;
    logic [SW-1:0]    seed_cnt, seed_cnt_nxt;
    logic [GW-1:0]    good_cnt, good_cnt_nxt;
    logic [BW-1:0]    bad_cnt, bad_cnt_nxt;
    logic             locked_nxt, err_nxt;
    logic [CNT_W-1:0] err_cnt_nxt, bit_cnt_nxt;

    logic clear;
    logic pred, match;
    logic seed_last, seed_zero, good_last, bad_last;

    assign clear  = rst | Load;
    assign pred   = ^(r & TAPS);
    assign match  = (Din == pred);
    assign r_din  = {r[WIDTH-2:0], Din};
    assign r_pred = {r[WIDTH-2:0], pred};

    assign seed_last = (seed_cnt == SEED_LAST);
    assign seed_zero = (r_din == '0);
    assign good_last = (good_cnt == GOOD_LAST);
    assign bad_last  = (bad_cnt == BAD_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_SEED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Din_valid) begin
            case (state)
                ST_SEED: begin
                    if (seed_last && !seed_zero) begin
                        state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!match) begin
                        state_nxt = ST_SEED;
                    end else if (good_last) begin
                        state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!match && bad_last) begin
                        state_nxt = ST_SEED;
                    end
                end
                default: state_nxt = ST_SEED;
            endcase
        end
    end

    always_comb begin
        r_nxt        = r;
        seed_cnt_nxt = seed_cnt;
        good_cnt_nxt = good_cnt;
        bad_cnt_nxt  = bad_cnt;
        locked_nxt   = locked;
        err_nxt      = 1'b0;
        err_cnt_nxt  = err_cnt;
        bit_cnt_nxt  = bit_cnt;
        if (Din_valid) begin
            case (state)
                ST_SEED: begin
                    r_nxt = r_din;
                    if (seed_last) begin
                        // an all-zero seed is a dead LFSR state: start over
                        seed_cnt_nxt = '0;
                        good_cnt_nxt = '0;
                    end else begin
                        seed_cnt_nxt = seed_cnt + SW'(1);
                    end
                end
                ST_VERIFY: begin
                    r_nxt = r_din;
                    if (!match) begin
                        seed_cnt_nxt = '0;
                        good_cnt_nxt = '0;
                    end else if (good_last) begin
                        good_cnt_nxt = '0;
                        bad_cnt_nxt  = '0;
                        locked_nxt   = 1'b1;
                    end else begin
                        good_cnt_nxt = good_cnt + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    // shift the prediction so a flipped bit costs one error only
                    r_nxt = r_pred;
                    if (!(&bit_cnt)) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                    if (!match) begin
                        err_nxt = 1'b1;
                        if (!(&err_cnt)) begin
                            err_cnt_nxt = err_cnt + CNT_W'(1);
                        end
                        if (bad_last) begin
                            bad_cnt_nxt  = '0;
                            seed_cnt_nxt = '0;
                            locked_nxt   = 1'b0;
                        end else begin
                            bad_cnt_nxt = bad_cnt + BW'(1);
                        end
                    end else begin
                        bad_cnt_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r        <= '0;
            seed_cnt <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            r        <= r_nxt;
            seed_cnt <= seed_cnt_nxt;
            good_cnt <= good_cnt_nxt;
            bad_cnt  <= bad_cnt_nxt;
            locked   <= locked_nxt;
            err      <= err_nxt;
            err_cnt  <= err_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prpg_checker.sv
// Scoreboard bench for prpg_checker: a reference PRPG stream is fed to the design.
// Expected outputs are queued as each bit is driven, then compared one cycle later.
module tb_prpg_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Load = 1'b0;
    logic        Din_valid = 1'b0;
    logic        Din = 1'b0;
    logic        locked, err;
    logic [15:0] err_cnt, bit_cnt;
    logic        s_locked, s_err;
    logic [3:0]  s_err_cnt, s_bit_cnt;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] err_cnt;
        logic [15:0] bit_cnt;
        logic [3:0]  sat_bit_cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    prpg_checker dut (
        .clk(clk), .rst(rst), .Load(Load),
        .Din_valid(Din_valid), .Din(Din),
        .locked(locked), .err(err),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prpg_checker #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .Load(Load),
        .Din_valid(Din_valid), .Din(Din),
        .locked(s_locked), .err(s_err),
        .err_cnt(s_err_cnt), .bit_cnt(s_bit_cnt)
    );

    always #5 clk = ~clk;

    // bit k (1-based) of the seed-4'b0100 generator stream
    function automatic logic sbit(input int k);
        logic [14:0] pat;
        pat = 15'b010011010111100;
        return pat[14 - ((k - 1) % 15)];
    endfunction

    function automatic exp_t mk(input logic l, input logic e,
                                input int ec, input int bc);
        exp_t v;
        v.locked      = l;
        v.err         = e;
        v.err_cnt     = 16'(ec);
        v.bit_cnt     = 16'(bc);
        v.sat_bit_cnt = (bc > 15) ? 4'd15 : 4'(bc);
        return v;
    endfunction

    function automatic exp_t clean_exp(input int k);
        return mk(k >= 8, 1'b0, 0, (k >= 8) ? k - 8 : 0);
    endfunction

    function automatic logic loss_inv(input int k);
        return (k >= 12 && k <= 14);
    endfunction

    function automatic exp_t loss_exp(input int k);
        int ec, bc;
        ec = (k < 12) ? 0 : (k >= 14) ? 3 : k - 11;
        bc = (k <= 8) ? 0 : (k <= 14) ? k - 8 : (k <= 22) ? 6 : k - 16;
        return mk((k >= 8 && k < 14) || k >= 22, loss_inv(k), ec, bc);
    endfunction

    function automatic exp_t observe();
        exp_t v;
        v.locked      = locked;
        v.err         = err;
        v.err_cnt     = err_cnt;
        v.bit_cnt     = bit_cnt;
        v.sat_bit_cnt = s_bit_cnt;
        return v;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d sat_bit_cnt=%0d",
                         v.locked, v.err, v.err_cnt, v.bit_cnt, v.sat_bit_cnt);
    endfunction

    task automatic drive(input logic ld, input logic vld, input logic d,
                         input exp_t e);
        Load      = ld;
        Din_valid = vld;
        Din       = d;
        q.push_back(e);
        @(posedge clk);
        #1;
        Load      = 1'b0;
        Din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t act, e;
        rst = 1'b1;
        Din_valid = 1'b1;
        Din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Din_valid = 1'b0;
        e = mk(1'b0, 1'b0, 0, 0);
        act = observe();
        vectors++;
        if (act !== e || s_err_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset: got %s want %s", fmt(act), fmt(e));
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        exp_t act, e;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL clean k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_single_err();
        exp_t act, e;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            drive(1'b0, 1'b1, sbit(k) ^ (k == 12),
                  mk(k >= 8, k == 12, (k >= 12) ? 1 : 0, (k >= 8) ? k - 8 : 0));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL single_err k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_loss_relock();
        exp_t act, e;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            drive(1'b0, 1'b1, sbit(k) ^ loss_inv(k), loss_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL loss k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_zero_seed();
        exp_t act, e;
        do_reset();
        for (int k = -3; k <= 20; k++) begin
            if (k <= 0) begin
                drive(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 0, 0));
            end else begin
                drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            end
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL zero_seed k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_load();
        exp_t act, e;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL load_pre k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
        drive(1'b1, 1'b1, ~sbit(13), mk(1'b0, 1'b0, 0, 0));
        e = q.pop_front();
        act = observe();
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL load_pulse: got %s want %s", fmt(act), fmt(e));
        end
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL load_post k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_gaps();
        exp_t act, e, held;
        do_reset();
        held = mk(1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL gaps_valid k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
            held = clean_exp(k);
            held.err = 1'b0;
            drive(1'b0, 1'b0, 1'($urandom_range(1)), held);
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL gaps_idle k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic test_rst_verify();
        exp_t act, e;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, sbit(k) ^ loss_inv(k), loss_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL rstv_pre k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
        rst = 1'b1;
        drive(1'b0, 1'b1, sbit(21), mk(1'b0, 1'b0, 0, 0));
        rst = 1'b0;
        e = q.pop_front();
        act = observe();
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL rstv_reset: got %s want %s", fmt(act), fmt(e));
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, sbit(k), clean_exp(k));
            e = q.pop_front();
            act = observe();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL rstv_post k=%0d: got %s want %s", k, fmt(act), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_loss_relock();
        test_zero_seed();
        test_load();
        test_gaps();
        test_rst_verify();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: got %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
